// File: rtl/alu_issue_ctrl_if.sv
// Request, ALU and response channels between decode, alu_issue_ctrl and the 64-bit ALU.
// The slave modport is the controller's view; the master modport is its surroundings.
interface alu_issue_ctrl_if #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 16
);
    logic             req_valid;
    logic             req_ready;
    logic [6:0]       req_opcode;
    logic [2:0]       req_funct3;
    logic             req_funct7b5;
    logic [XLEN-1:0]  req_rs1;
    logic [XLEN-1:0]  req_rs2;
    logic [XLEN-1:0]  req_imm;

    logic [XLEN-1:0]  alu_a;
    logic [XLEN-1:0]  alu_b;
    logic [3:0]       alu_op;
    logic [XLEN-1:0]  alu_result;
    logic             alu_zero;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [XLEN-1:0]  rsp_result;
    logic             rsp_taken;
    logic             rsp_illegal;

    logic [CNT_W-1:0] ops_issued;
    logic [CNT_W-1:0] ops_illegal;

    modport slave (
        input  req_valid, req_opcode, req_funct3, req_funct7b5,
               req_rs1, req_rs2, req_imm,
               alu_result, alu_zero, rsp_ready,
        output req_ready, alu_a, alu_b, alu_op,
               rsp_valid, rsp_result, rsp_taken, rsp_illegal,
               ops_issued, ops_illegal
    );

    modport master (
        output req_valid, req_opcode, req_funct3, req_funct7b5,
               req_rs1, req_rs2, req_imm,
               alu_result, alu_zero, rsp_ready,
        input  req_ready, alu_a, alu_b, alu_op,
               rsp_valid, rsp_result, rsp_taken, rsp_illegal,
               ops_issued, ops_illegal
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Decode-to-ALU issue controller: maps RV64 fields to ALUOp, drives registered operands,
// captures the ALU result one cycle later and returns it with the branch outcome.
module alu_issue_ctrl #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 16
) (
    input  logic           clk,
    input  logic           reset,
    alu_issue_ctrl_if.slave bus
);
    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_NONE = 4'b1111;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state_q, state_d;
    logic [XLEN-1:0]  a_q, a_d, b_q, b_d, res_q, res_d;
    logic [3:0]       op_q, op_d;
    logic             br_q, br_d, bne_q, bne_d;
    logic             taken_q, taken_d, ill_q, ill_d;
    logic [CNT_W-1:0] iss_q, iss_d, illcnt_q, illcnt_d;

    logic             dec_legal, dec_imm, dec_br, dec_bne;
    logic [3:0]       dec_op;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    // Instruction decode: ALUOp, b-source and branch flavour
    always_comb begin
        dec_legal = 1'b1;
        dec_op    = OP_ADD;
        dec_imm   = 1'b0;
        dec_br    = 1'b0;
        dec_bne   = 1'b0;
        unique case (bus.req_opcode)
            7'b0110011: begin
                unique case (bus.req_funct3)
                    3'b000:  dec_op = bus.req_funct7b5 ? OP_SUB : OP_ADD;
                    3'b111:  dec_op = OP_AND;
                    3'b110:  dec_op = OP_OR;
                    default: dec_legal = 1'b0;
                endcase
            end
            7'b0010011: begin
                dec_imm = 1'b1;
                unique case (bus.req_funct3)
                    3'b000:  dec_op = OP_ADD;
                    3'b111:  dec_op = OP_AND;
                    3'b110:  dec_op = OP_OR;
                    default: dec_legal = 1'b0;
                endcase
            end
            7'b0000011, 7'b0100011: dec_imm = 1'b1;
            7'b1100011: begin
                dec_op  = OP_SUB;
                dec_br  = 1'b1;
                dec_bne = (bus.req_funct3 == 3'b001);
                if (bus.req_funct3 != 3'b000 && bus.req_funct3 != 3'b001)
                    dec_legal = 1'b0;
            end
            7'b0001011: begin
                dec_op = OP_NOR;
                if (bus.req_funct3 != 3'b000)
                    dec_legal = 1'b0;
            end
            default: dec_legal = 1'b0;
        endcase
    end

    // Next state: illegal requests bypass EXEC and leave the ALU operands untouched
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        br_d     = br_q;
        bne_d    = bne_q;
        res_d    = res_q;
        taken_d  = taken_q;
        ill_d    = ill_q;
        iss_d    = iss_q;
        illcnt_d = illcnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    if (dec_legal) begin
                        a_d     = bus.req_rs1;
                        b_d     = dec_imm ? bus.req_imm : bus.req_rs2;
                        op_d    = dec_op;
                        br_d    = dec_br;
                        bne_d   = dec_bne;
                        iss_d   = sat_inc(iss_q);
                        state_d = EXEC;
                    end else begin
                        res_d    = '0;
                        taken_d  = 1'b0;
                        ill_d    = 1'b1;
                        illcnt_d = sat_inc(illcnt_q);
                        state_d  = RESP;
                    end
                end
            end
            EXEC: begin
                res_d   = bus.alu_result;
                taken_d = br_q & (bne_q ? ~bus.alu_zero : bus.alu_zero);
                ill_d   = 1'b0;
                state_d = RESP;
            end
            RESP: begin
                if (bus.rsp_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= OP_NONE;
            br_q     <= 1'b0;
            bne_q    <= 1'b0;
            res_q    <= '0;
            taken_q  <= 1'b0;
            ill_q    <= 1'b0;
            iss_q    <= '0;
            illcnt_q <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            br_q     <= br_d;
            bne_q    <= bne_d;
            res_q    <= res_d;
            taken_q  <= taken_d;
            ill_q    <= ill_d;
            iss_q    <= iss_d;
            illcnt_q <= illcnt_d;
        end
    end

    assign bus.req_ready   = (state_q == IDLE);
    assign bus.rsp_valid   = (state_q == RESP);
    assign bus.alu_a       = a_q;
    assign bus.alu_b       = b_q;
    assign bus.alu_op      = op_q;
    assign bus.rsp_result  = res_q;
    assign bus.rsp_taken   = taken_q;
    assign bus.rsp_illegal = ill_q;
    assign bus.ops_issued  = iss_q;
    assign bus.ops_illegal = illcnt_q;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural ALU, spec-level reference model, directed and random ops.
module tb_alu_issue_ctrl;
    localparam int XLEN  = 64;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    localparam logic [3:0] A_AND = 4'b0000;
    localparam logic [3:0] A_OR  = 4'b0001;
    localparam logic [3:0] A_ADD = 4'b0010;
    localparam logic [3:0] A_SUB = 4'b0110;
    localparam logic [3:0] A_NOR = 4'b1100;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_issue_ctrl_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

    alu_issue_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // The ALU the controller talks to
    logic [XLEN-1:0] alu_res;
    always_comb begin
        alu_res = '0;
        case (bus.alu_op)
            A_AND:   alu_res = bus.alu_a & bus.alu_b;
            A_OR:    alu_res = bus.alu_a | bus.alu_b;
            A_ADD:   alu_res = bus.alu_a + bus.alu_b;
            A_SUB:   alu_res = bus.alu_a - bus.alu_b;
            A_NOR:   alu_res = ~(bus.alu_a | bus.alu_b);
            default: alu_res = '0;
        endcase
    end
    assign bus.alu_result = alu_res;
    assign bus.alu_zero   = (alu_res == '0);

    int checks   = 0;
    int failures = 0;
    int exp_iss, exp_ill;
    logic [3:0]  last_op;
    logic [63:0] last_a, last_b;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    function automatic void ref_model(
        input  logic [6:0]  opc,
        input  logic [2:0]  f3,
        input  logic        f7,
        input  logic [63:0] rs1,
        input  logic [63:0] rs2,
        input  logic [63:0] imm,
        output bit          legal,
        output logic [3:0]  op,
        output logic [63:0] b,
        output logic [63:0] res,
        output bit          taken
    );
        legal = 1'b1;
        taken = 1'b0;
        op    = A_ADD;
        b     = rs2;
        case (opc)
            7'b0110011, 7'b0010011: begin
                if (opc == 7'b0010011) b = imm;
                if (f3 == 3'b000)      op = (opc == 7'b0110011 && f7) ? A_SUB : A_ADD;
                else if (f3 == 3'b111) op = A_AND;
                else if (f3 == 3'b110) op = A_OR;
                else                   legal = 1'b0;
            end
            7'b0000011, 7'b0100011: b = imm;
            7'b1100011: begin
                op = A_SUB;
                if (f3 == 3'b000)      taken = (rs1 == rs2);
                else if (f3 == 3'b001) taken = (rs1 != rs2);
                else                   legal = 1'b0;
            end
            7'b0001011: begin
                op = A_NOR;
                if (f3 != 3'b000) legal = 1'b0;
            end
            default: legal = 1'b0;
        endcase
        case (op)
            A_AND:   res = rs1 & b;
            A_OR:    res = rs1 | b;
            A_SUB:   res = rs1 - b;
            A_NOR:   res = ~(rs1 | b);
            default: res = rs1 + b;
        endcase
        if (!legal) begin
            res   = '0;
            taken = 1'b0;
        end
    endfunction

    task automatic junk_req();
        bus.req_opcode   = 7'($urandom);
        bus.req_funct3   = 3'($urandom);
        bus.req_funct7b5 = 1'($urandom);
        bus.req_rs1      = {$urandom, $urandom};
        bus.req_rs2      = {$urandom, $urandom};
        bus.req_imm      = {$urandom, $urandom};
    endtask

    // Called just after a negedge with the controller idle; returns the same way
    task automatic run_op(
        input logic [6:0]  opc,
        input logic [2:0]  f3,
        input logic        f7,
        input logic [63:0] rs1,
        input logic [63:0] rs2,
        input logic [63:0] imm,
        input int          stall
    );
        bit          legal, taken;
        logic [3:0]  op;
        logic [63:0] b, res;
        ref_model(opc, f3, f7, rs1, rs2, imm, legal, op, b, res, taken);
        bus.req_opcode   = opc;
        bus.req_funct3   = f3;
        bus.req_funct7b5 = f7;
        bus.req_rs1      = rs1;
        bus.req_rs2      = rs2;
        bus.req_imm      = imm;
        bus.req_valid    = 1'b1;
        chk("req_ready_idle", bus.req_ready, 1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        junk_req();
        if (legal) begin
            exp_iss = sat(exp_iss + 1);
            last_op = op;
            last_a  = rs1;
            last_b  = b;
            chk("exec_rsp_valid", bus.rsp_valid, 0);
            chk("exec_req_ready", bus.req_ready, 0);
            chk("alu_op", bus.alu_op, op);
            chk("alu_a", bus.alu_a, rs1);
            chk("alu_b", bus.alu_b, b);
            @(negedge clk);
        end else begin
            exp_ill = sat(exp_ill + 1);
            chk("ill_alu_op_held", bus.alu_op, last_op);
            chk("ill_alu_a_held", bus.alu_a, last_a);
            chk("ill_alu_b_held", bus.alu_b, last_b);
        end
        chk("rsp_valid", bus.rsp_valid, 1);
        chk("rsp_result", bus.rsp_result, res);
        chk("rsp_taken", bus.rsp_taken, taken);
        chk("rsp_illegal", bus.rsp_illegal, !legal);
        chk("ops_issued", bus.ops_issued, exp_iss);
        chk("ops_illegal", bus.ops_illegal, exp_ill);
        for (int i = 0; i < stall; i++) begin
            bus.req_valid = 1'b1;
            junk_req();
            @(negedge clk);
            chk("stall_rsp_valid", bus.rsp_valid, 1);
            chk("stall_req_ready", bus.req_ready, 0);
            chk("stall_result", bus.rsp_result, res);
            chk("stall_taken", bus.rsp_taken, taken);
            chk("stall_illegal", bus.rsp_illegal, !legal);
            chk("stall_issued", bus.ops_issued, exp_iss);
            chk("stall_ill_cnt", bus.ops_illegal, exp_ill);
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("done_rsp_valid", bus.rsp_valid, 0);
        chk("done_req_ready", bus.req_ready, 1);
        bus.rsp_ready = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
        chk({tag, "_rsp_result"}, bus.rsp_result, 0);
        chk({tag, "_alu_op"}, bus.alu_op, 4'b1111);
        chk({tag, "_alu_a"}, bus.alu_a, 0);
        chk({tag, "_issued"}, bus.ops_issued, 0);
        chk({tag, "_illegal"}, bus.ops_illegal, 0);
        exp_iss = 0;
        exp_ill = 0;
        last_op = 4'b1111;
        last_a  = '0;
        last_b  = '0;
    endtask

    logic [6:0] opc_tab [7] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                7'b1100011, 7'b0001011, 7'b1111111};

    initial begin
        logic [63:0] r1, r2;
        logic [11:0] i12;
        logic [6:0]  opc;
        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        junk_req();
        #12;
        check_reset_state("reset");
        chk("reset_req_ready", bus.req_ready, 1);
        @(negedge clk);
        reset = 1'b0;

        run_op(7'b0110011, 3'b000, 1'b0, 64'd5, 64'd7, 64'd0, 0);
        run_op(7'b1100011, 3'b000, 1'b0, 64'hDEAD_BEEF, 64'hDEAD_BEEF, 64'd0, 1);
        run_op(7'b1100011, 3'b001, 1'b0, 64'd3, 64'd3, 64'd0, 0);
        run_op(7'b0001011, 3'b000, 1'b0, 64'd0, 64'hFFFF_FFFF_0000_0000, 64'd0, 0);
        run_op(7'b0110011, 3'b001, 1'b0, 64'd9, 64'd4, 64'd0, 0);
        run_op(7'b0010011, 3'b111, 1'b1, 64'hF0F0, 64'd1, 64'hFF00, 5);

        // Reset while the op is in EXEC
        run_op(7'b0110011, 3'b110, 1'b0, 64'd1, 64'd2, 64'd0, 0);
        bus.req_opcode = 7'b0110011; bus.req_funct3 = 3'b000; bus.req_funct7b5 = 1'b1;
        bus.req_rs1 = 64'd10; bus.req_rs2 = 64'd4; bus.req_valid = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        #2 reset = 1'b1;
        #1 check_reset_state("rst_exec");
        @(negedge clk);
        reset = 1'b0;
        run_op(7'b0110011, 3'b000, 1'b1, 64'd10, 64'd4, 64'd0, 0);

        // Reset while the response is waiting in RESP
        bus.req_opcode = 7'b0000011; bus.req_funct3 = 3'b011;
        bus.req_rs1 = 64'd100; bus.req_imm = 64'd8; bus.req_valid = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_rsp_valid", bus.rsp_valid, 1);
        #2 reset = 1'b1;
        #1 check_reset_state("rst_resp");
        @(negedge clk);
        reset = 1'b0;

        // Random traffic, long enough to saturate the narrow counters
        for (int n = 0; n < 60; n++) begin
            opc = opc_tab[$urandom_range(0, 6)];
            r1  = {$urandom, $urandom};
            r2  = ($urandom_range(0, 1) == 1) ? r1 : {$urandom, $urandom};
            i12 = 12'($urandom);
            run_op(opc, 3'($urandom), 1'($urandom), r1, r2, {{52{i12[11]}}, i12},
                   $urandom_range(0, 2));
        end
        chk("sat_issued", bus.ops_issued, CMAX);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
